// File: rtl/imem_loader.sv
// Serial byte loader for instruction memory: packs big-endian bytes into words, writes them, holds the CPU meanwhile.
// Latency: one write cycle after every 4th accepted byte; backpressure by dropping in_ready outside RECV.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          MAX_WORDS = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load_start,
   input  logic [15:0] load_words,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   output logic        mem_write_enabled,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err_length
);

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   state_t      state;
   logic [15:0] len;
   logic [15:0] word_idx;
   logic [1:0]  byte_cnt;
   logic [31:0] asm_word;
   logic        loaded;

   logic        len_ok;
   logic [15:0] idx_next;
   logic [31:0] word_next;

   assign len_ok    = (load_words != 16'd0) && ({1'b0, load_words} <= MAX_LEN);
   assign idx_next  = word_idx + 16'd1;
   assign word_next = {asm_word[23:0], in_byte};

   // Decoded only from registered state, so in_valid never reaches in_ready.
   assign in_ready = (state == RECV);
   assign busy     = (state != IDLE);
   assign cpu_hold = (state != IDLE) || !loaded;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         len               <= 16'd0;
         word_idx          <= 16'd0;
         byte_cnt          <= 2'd0;
         asm_word          <= 32'd0;
         loaded            <= 1'b0;
         mem_write_enabled <= 1'b0;
         mem_address       <= 32'd0;
         mem_data          <= 32'd0;
         done              <= 1'b0;
         err_length        <= 1'b0;
      end else begin
         mem_write_enabled <= 1'b0;
         mem_address       <= 32'd0;
         mem_data          <= 32'd0;
         done              <= 1'b0;
         err_length        <= 1'b0;
         case (state)
            IDLE: begin
               if (load_start) begin
                  if (len_ok) begin
                     len      <= load_words;
                     word_idx <= 16'd0;
                     byte_cnt <= 2'd0;
                     state    <= RECV;
                  end else begin
                     err_length <= 1'b1;
                  end
               end
            end
            RECV: begin
               if (in_valid) begin
                  asm_word <= word_next;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     state             <= WRITE;
                     mem_write_enabled <= 1'b1;
                     mem_data          <= word_next;
                     mem_address       <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                  end
               end
            end
            WRITE: begin
               word_idx <= idx_next;
               byte_cnt <= 2'd0;
               if (idx_next == len) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state <= RECV;
               end
            end
            DONE: begin
               state  <= IDLE;
               loaded <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load_start vectors, directed corner sequences, randomized loads vs a word-list model.
module tb_imem_loader;
   localparam logic [31:0] BASE = 32'h100;
   localparam int          MAXW = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        load_start = 1'b0;
   logic [15:0] load_words = 16'd0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_byte = 8'd0;
   logic        in_ready;
   logic        mem_write_enabled;
   logic [31:0] mem_address;
   logic [31:0] mem_data;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err_length;

   imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
      .clock(clock), .reset(reset), .load_start(load_start), .load_words(load_words),
      .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
      .mem_write_enabled(mem_write_enabled), .mem_address(mem_address), .mem_data(mem_data),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err_length(err_length)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   typedef struct {
      logic [15:0] words;
      logic        exp_err;
      logic        exp_busy;
      logic        exp_rdy;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   wr_t         wr_q[$];
   logic [7:0]  src_q[$];

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (mem_write_enabled) begin
         wr_q.push_back('{mem_address, mem_data, cyc});
      end else begin
         checks++;
         if (mem_address != 32'd0 || mem_data != 32'd0) begin
            errors++;
            $display("FAIL idle_bus: addr=%h data=%h, required 0", mem_address, mem_data);
         end
      end
      if (done) done_cnt++;
      if (err_length) err_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      load_start = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic start_load(input int w);
      @(negedge clock);
      load_start = 1'b1;
      load_words = 16'(w);
      @(negedge clock);
      load_start = 1'b0;
   endtask

   // Valid/ready source: a byte advances only when valid was offered while ready was high.
   task automatic feed(input int first, input int n, input int gap);
      int   i = first;
      int   budget = 0;
      logic rdy;
      while (i < first + n && budget < 3000) begin
         @(negedge clock);
         in_valid = ($urandom_range(99) >= gap);
         in_byte  = src_q[i];
         rdy      = in_ready;
         @(posedge clock);
         if (in_valid && rdy) i++;
         budget++;
      end
      if (i < first + n) chk("feed_timeout", 32'(i), 32'(first + n));
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int exp_cnt);
      int b = 0;
      while (done_cnt < exp_cnt && b < 60) begin
         @(posedge clock);
         b++;
      end
      chk("done_seen", 32'(done_cnt), 32'(exp_cnt));
      @(negedge clock);
   endtask

   task automatic check_writes(input int nw);
      logic [31:0] exp_d;
      chk("wr_count", 32'(wr_q.size()), 32'(nw));
      for (int i = 0; i < nw && i < wr_q.size(); i++) begin
         exp_d = {src_q[4*i], src_q[4*i+1], src_q[4*i+2], src_q[4*i+3]};
         chk($sformatf("wr%0d_addr", i), wr_q[i].addr, BASE + 32'(4 * i));
         chk($sformatf("wr%0d_data", i), wr_q[i].data, exp_d);
      end
   endtask

   task automatic run_load(input int nw, input int gap);
      int d0 = done_cnt;
      wr_q.delete();
      start_load(nw);
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("hold_during_load", 32'(cpu_hold), 32'd1);
      feed(0, 4 * nw, gap);
      wait_done(d0 + 1);
      check_writes(nw);
      if (gap == 0 && nw > 1 && wr_q.size() > 1)
         chk("write_spacing", 32'(wr_q[1].cyc - wr_q[0].cyc), 32'd5);
      chk("hold_after_load", 32'(cpu_hold), 32'd0);
      chk("busy_after_load", 32'(busy), 32'd0);
   endtask

   vec_t tbl[5];

   initial begin
      int nw;
      int e0;
      tbl[0] = '{16'd0,      1'b1, 1'b0, 1'b0};
      tbl[1] = '{16'd1,      1'b0, 1'b1, 1'b1};
      tbl[2] = '{16'(MAXW),  1'b0, 1'b1, 1'b1};
      tbl[3] = '{16'(MAXW+1),1'b1, 1'b0, 1'b0};
      tbl[4] = '{16'hFFFF,   1'b1, 1'b0, 1'b0};

      // Outputs while reset is held
      #2;
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdy", 32'(in_ready), 32'd0);
      chk("rst_we", 32'(mem_write_enabled), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err_length), 32'd0);
      do_reset();

      // Quiet period after reset release
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         chk("quiet_hold", 32'(cpu_hold), 32'd1);
         chk("quiet_busy", 32'(busy), 32'd0);
         chk("quiet_rdy", 32'(in_ready), 32'd0);
      end
      chk("quiet_writes", 32'(wr_q.size()), 32'd0);

      // load_start vector table
      for (int i = 0; i < 5; i++) begin
         do_reset();
         start_load(int'(tbl[i].words));
         chk($sformatf("tbl%0d_err", i), 32'(err_length), 32'(tbl[i].exp_err));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
         chk($sformatf("tbl%0d_rdy", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
         chk($sformatf("tbl%0d_hold", i), 32'(cpu_hold), 32'd1);
         @(negedge clock);
         chk($sformatf("tbl%0d_err_end", i), 32'(err_length), 32'd0);
         chk($sformatf("tbl%0d_busy2", i), 32'(busy), 32'(tbl[i].exp_busy));
      end
      do_reset();

      // Two-word load with continuous valid
      src_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_load(2, 0);

      // Rejected lengths after a completed load keep the CPU released
      wr_q.delete();
      e0 = err_cnt;
      start_load(0);
      chk("rej0_err", 32'(err_length), 32'd1);
      chk("rej0_hold", 32'(cpu_hold), 32'd0);
      start_load(MAXW + 1);
      chk("rejmax_err", 32'(err_length), 32'd1);
      chk("rejmax_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clock);
      chk("rej_pulses", 32'(err_cnt - e0), 32'd2);
      chk("rej_writes", 32'(wr_q.size()), 32'd0);
      chk("rej_hold", 32'(cpu_hold), 32'd0);

      // Three-word load with heavy valid gaps
      src_q.delete();
      for (int i = 0; i < 12; i++) src_q.push_back(8'($urandom_range(255)));
      run_load(3, 50);

      // load_start during RECV is ignored and the length stays at 2
      src_q.delete();
      for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom_range(255)));
      wr_q.delete();
      e0 = done_cnt;
      start_load(2);
      feed(0, 3, 0);
      start_load(1);
      chk("ign_err", 32'(err_length), 32'd0);
      chk("ign_busy", 32'(busy), 32'd1);
      feed(3, 5, 20);
      wait_done(e0 + 1);
      check_writes(2);

      // Reset after the sixth byte of a four-word load
      src_q.delete();
      for (int i = 0; i < 16; i++) src_q.push_back(8'($urandom_range(255)));
      wr_q.delete();
      start_load(4);
      feed(0, 6, 30);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_hold", 32'(cpu_hold), 32'd1);
      chk("abort_rdy", 32'(in_ready), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (20) @(negedge clock);
      chk("abort_state_busy", 32'(busy), 32'd0);
      chk("abort_state_hold", 32'(cpu_hold), 32'd1);
      check_writes(1);

      // Full-length load and randomized loads
      src_q.delete();
      for (int i = 0; i < 4 * MAXW; i++) src_q.push_back(8'($urandom_range(255)));
      run_load(MAXW, 10);
      for (int k = 0; k < 6; k++) begin
         nw = $urandom_range(MAXW, 1);
         src_q.delete();
         for (int i = 0; i < 4 * nw; i++) src_q.push_back(8'($urandom_range(255)));
         run_load(nw, $urandom_range(70));
      end

      repeat (3) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 0, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 256, largest legal load length in words.
REQ-003 Port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port load_start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 Port load_words  input  16  number of 32-bit words to load; sampled on an accepted load_start.
REQ-007 Port in_valid  input  1  in_byte carries a valid byte.
REQ-008 Port in_byte  input  8  serial program byte.
REQ-009 Port in_ready  output  1  loader accepts in_byte this cycle.
REQ-010 Port mem_write_enabled  output  1  write strobe to instruction memory write_enabled.
REQ-011 Port mem_address  output  32  byte address to instruction memory input_address.
REQ-012 Port mem_data  output  32  word to instruction memory input_data.
REQ-013 Port cpu_hold  output  1  holds the CPU (pc) in reset while high.
REQ-014 Port busy  output  1  high in any state other than IDLE.
REQ-015 Port done  output  1  one-cycle pulse on load completion.
REQ-016 Port err_length  output  1  one-cycle pulse on a rejected load_start.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, RECV, WRITE and DONE.
REQ-018 In IDLE, a load_start with 1 <= load_words <= MAX_WORDS SHALL latch the length, clear word_idx and byte_cnt, and enter RECV on the next cycle.
REQ-019 In IDLE, a load_start with load_words == 0 or load_words > MAX_WORDS SHALL pulse err_length for one cycle, perform no write, leave cpu_hold unchanged, and remain in IDLE.
REQ-020 load_start SHALL be ignored in RECV, WRITE and DONE.
REQ-021 in_ready SHALL be 1 only in RECV; a byte transfers when in_valid and in_ready are both 1 on a rising edge.
REQ-022 Bytes SHALL be assembled big-endian: the first accepted byte of a word fills bits 31:24 and the fourth fills bits 7:0.
REQ-023 in_valid low in RECV SHALL stall with no state change and no timeout.
REQ-024 On the fourth accepted byte, the FSM SHALL enter WRITE on the next cycle.
REQ-025 WRITE SHALL last exactly one cycle with mem_write_enabled = 1, mem_data = the assembled word, and mem_address = BASE_ADDR + 4*word_idx (32-bit, modulo 2^32).
REQ-026 mem_write_enabled SHALL be 0 in every state except WRITE; mem_address and mem_data SHALL be 0 outside WRITE.
REQ-027 On exit from WRITE, word_idx SHALL increment; if the new word_idx equals the latched length the FSM SHALL enter DONE, otherwise RECV with byte_cnt = 0.
REQ-028 DONE SHALL last one cycle with done = 1, then return to IDLE.
REQ-029 cpu_hold SHALL be 1 in RECV, WRITE and DONE, and 1 in IDLE until the first completed load; it SHALL be 0 in IDLE after any completed load.
REQ-030 Throughput SHALL be at most one word per 5 cycles: 4 byte-accept cycles plus 1 WRITE cycle.
REQ-031 All outputs SHALL be registered or decoded solely from registered state; no combinational path SHALL exist from in_valid to in_ready.

Reset
REQ-032 Asserting reset SHALL asynchronously force IDLE, word_idx = 0, byte_cnt = 0, the assembly register = 0, and the loaded flag = 0.
REQ-033 During and after reset: in_ready = 0, mem_write_enabled = 0, mem_address = 0, mem_data = 0, busy = 0, done = 0, err_length = 0, cpu_hold = 1.
REQ-034 Reset asserted mid-load SHALL abandon the load with no further writes and require a fresh load_start.

Verification
REQ-035 Reset release, no stimulus -> cpu_hold = 1, busy = 0, in_ready = 0, no writes for 20 cycles.
REQ-036 Start with load_words = 2, bytes 12 34 56 78 AA BB CC DD, in_valid held high -> writes 0x12345678 @0x0 and 0xAABBCCDD @0x4, done pulse, cpu_hold = 0 afterward.
REQ-037 load_words = 0, then load_words = MAX_WORDS+1 -> err_length pulses each time, no writes, state stays IDLE.
REQ-038 Random in_valid gaps on a 3-word load with BASE_ADDR = 0x100 -> exactly 3 writes at 0x100, 0x104, 0x108 with correct data, and no byte accepted while in_ready = 0.
REQ-039 load_start pulsed during RECV -> ignored and length unchanged; reset after the 6th byte of a 4-word load -> IDLE, cpu_hold = 1, only 1 write observed.
